// File: rtl/sap_datapath_pkg.sv
// sap_datapath_pkg
//   Shared definitions for the SAP datapath: command FSM state encoding,
//   ALU opcodes and the bit positions of C/Z/N/V inside the 4-bit flags word.
package sap_datapath_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  // Flags word is {C,Z,N,V}
  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 1;
  localparam int FLG_V = 0;

  function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                            input logic n, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_C] = c;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/sap_datapath_if.sv
// sap_datapath_if
//   Command/result bus between the controller (master) and the datapath (slave).
//   Ports:
//     cmd_valid/cmd_ready  command handshake (accepted when both high)
//     cmd_op/src_a/src_b/dst/flg_we  command fields
//     bus, bus_valid, done  result and its one-cycle strobes
//     flags                 registered {C,Z,N,V}
interface sap_datapath_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AW-1:0]    cmd_src_a;
  logic [AW-1:0]    cmd_src_b;
  logic [AW-1:0]    cmd_dst;
  logic             cmd_flg_we;
  logic [WIDTH-1:0] bus;
  logic             bus_valid;
  logic             done;
  logic [3:0]       flags;

  modport master (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_flg_we,
    input  cmd_ready, bus, bus_valid, done, flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_flg_we,
    output cmd_ready, bus, bus_valid, done, flags
  );
endinterface

// File: rtl/sap_datapath_alu.sv
// sap_alu
//   Combinational ALU for the SAP datapath.
//   Ports:
//     a, b    operands (WIDTH)
//     op      opcode (OP_ADD..OP_SHR)
//     result  op result mod 2^WIDTH
//     flags   {C,Z,N,V} that this result would produce
module sap_alu
  import sap_datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             c;
  logic             v;

  always_comb begin
    // SUB shares the adder as a + ~b + 1, so C=1 means "no borrow"
    b_eff  = (op == OP_SUB) ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        // overflow: both adder inputs share a sign that the sum does not
        v      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_PASS: result = a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        c      = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        c      = a[0];
      end
      default: result = '0;
    endcase
    flags = pack_flags(c, (result == '0), result[WIDTH-1], v);
  end

endmodule

// File: rtl/sap_datapath.sv
// sap_datapath
//   Register file (NUM_REGS x WIDTH) plus ALU under a 4-cycle command FSM
//   IDLE -> FETCH -> EXEC -> WB. Each result appears on bus with a one-cycle
//   bus_valid/done strobe during WB; flags update at the end of WB when the
//   command asked for it.
//   Ports:
//     clk, reset        clock, asynchronous active-low reset
//     cmd               command/result interface (slave side)
//     wr_en/addr/data   external register load, any state
//     rd_addr/rd_data   combinational register peek
//     wr_conflict       external write dropped in favour of writeback
module sap_datapath
  import sap_datapath_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NUM_REGS = 4,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  sap_datapath_if.slave    cmd,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             wr_conflict
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic             flg_we_q, flg_we_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       nflags_q, nflags_d, flags_q, flags_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;

  sap_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (opa_q),
    .b      (opb_q),
    .op     (op_q),
    .result (alu_res),
    .flags  (alu_flags)
  );

  // IDLE: latch command fields on handshake
  // FETCH: read operands from the pre-edge register file
  // EXEC: register ALU result and prospective flags
  // WB: commit to register file and (optionally) flags
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    dst_d    = dst_q;
    flg_we_d = flg_we_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    nflags_d = nflags_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d     = cmd.cmd_op;
          src_a_d  = cmd.cmd_src_a;
          src_b_d  = cmd.cmd_src_b;
          dst_d    = cmd.cmd_dst;
          flg_we_d = cmd.cmd_flg_we;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        opa_d   = regs_q[src_a_q];
        opb_d   = regs_q[src_b_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d    = alu_res;
        nflags_d = alu_flags;
        state_d  = ST_WB;
      end
      ST_WB: begin
        if (flg_we_q) flags_d = nflags_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file: external write first, writeback overrides it on the same index
  always_comb begin
    regs_d      = regs_q;
    wr_conflict = 1'b0;
    if (wr_en) regs_d[wr_addr] = wr_data;
    if (state_q == ST_WB) begin
      regs_d[dst_q] = res_q;
      wr_conflict   = wr_en && (wr_addr == dst_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      flg_we_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      nflags_q <= '0;
      flags_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      dst_q    <= dst_d;
      flg_we_q <= flg_we_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      nflags_q <= nflags_d;
      flags_q  <= flags_d;
      regs_q   <= regs_d;
    end
  end

  // res_q is only loaded in EXEC, so it already holds the last result and
  // doubles as the bus register; it is new exactly during WB.
  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.bus       = res_q;
  assign cmd.bus_valid = (state_q == ST_WB);
  assign cmd.done      = (state_q == ST_WB);
  assign cmd.flags     = flags_q;
  assign rd_data       = regs_q[rd_addr];

endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath
//   Directed and randomized commands against sap_datapath (WIDTH=8, NUM_REGS=4).
//   Expected results come from an arithmetic reference model and go through a
//   scoreboard queue consumed by an independent monitor.
module tb_sap_datapath;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] rd_addr, rd_addr_drv, rd_addr_mon;
  logic          mon_active;
  logic [W-1:0]  rd_data;
  logic          wr_conflict;

  always #5 clk = ~clk;

  sap_datapath_if #(.WIDTH(W), .AW(AW)) bif();

  sap_datapath #(.WIDTH(W), .NUM_REGS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (bif),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_conflict (wr_conflict)
  );

  assign rd_addr = mon_active ? rd_addr_mon : rd_addr_drv;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           dst;
    bit           conflict;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           passes = 0;
  int           issued = 0;
  int           seen   = 0;
  logic [W-1:0] mregs [N];
  logic [3:0]   mflags;
  bit           wq_en   [4];
  int           wq_addr [4];
  logic [W-1:0] wq_data [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU: plain integer arithmetic on unsigned/signed interpretations
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output logic [3:0] f);
    int m, h, full, sa, sb, ss;
    bit c, v;
    m = 1 << W; h = m / 2; c = 0; v = 0; ss = 0; full = 0;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    case (op)
      0: begin full = a + b; r = full % m; c = (full >= m); ss = sa + sb; v = (ss >= h) || (ss < -h); end
      1: begin r = (a - b + m) % m; c = (a >= b); ss = sa - sb; v = (ss >= h) || (ss < -h); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a;
      6: begin r = (a * 2) % m; c = (a >= h); end
      7: begin r = a / 2; c = (a % 2 == 1); end
      default: r = 0;
    endcase
    f = {c, (r == 0), (r >= h), v};
  endfunction

  task automatic clear_wq();
    for (int k = 0; k < 4; k++) begin
      wq_en[k] = 0; wq_addr[k] = 0; wq_data[k] = '0;
    end
  endtask

  task automatic ext_write(input int a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    mregs[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic peek(input string name, input int a, input logic [W-1:0] exp);
    #2;
    rd_addr_drv = AW'(a);
    #1;
    chk(name, int'(rd_data), int'(exp));
  endtask

  // Issue one command at cycle 0; wq_* holds external writes for cycles 0..3.
  task automatic run_cmd(input int op, input int sa, input int sb, input int dst,
                         input bit flg, input bit busy_valid);
    logic [W-1:0] m [N];
    logic [3:0]   f;
    int           r, a, b;
    exp_t         e;
    m = mregs;
    if (wq_en[0]) m[wq_addr[0]] = wq_data[0];
    a = int'(m[sa]);
    b = int'(m[sb]);
    for (int k = 1; k < 3; k++) if (wq_en[k]) m[wq_addr[k]] = wq_data[k];
    ref_alu(op, a, b, r, f);
    e.conflict = wq_en[3] && (wq_addr[3] == dst);
    if (wq_en[3] && !e.conflict) m[wq_addr[3]] = wq_data[3];
    m[dst] = W'(r);
    if (flg) mflags = f;
    e.res = W'(r); e.flg = mflags; e.dst = dst;
    sbq.push_back(e);
    mregs = m;
    issued++;

    chk("cmd_ready_idle", int'(bif.cmd_ready), 1);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        bif.cmd_valid = 1'b1; bif.cmd_op = 3'(op);
        bif.cmd_src_a = AW'(sa); bif.cmd_src_b = AW'(sb);
        bif.cmd_dst = AW'(dst); bif.cmd_flg_we = flg;
      end else begin
        bif.cmd_valid = busy_valid; bif.cmd_op = 3'($urandom);
        bif.cmd_src_a = AW'($urandom); bif.cmd_src_b = AW'($urandom);
        bif.cmd_dst = AW'($urandom); bif.cmd_flg_we = 1'($urandom);
      end
      if (k == 1) chk("cmd_ready_busy", int'(bif.cmd_ready), 0);
      if (k == 2) chk("bus_valid_early", int'(bif.bus_valid), 0);
      if (k == 3) chk("bus_valid_cycle3", int'(bif.bus_valid), 1);
      wr_en = wq_en[k]; wr_addr = AW'(wq_addr[k]); wr_data = wq_data[k];
      tick();
    end
    bif.cmd_valid = 1'b0;
    wr_en = 1'b0;
    clear_wq();
  endtask

  task automatic op_d(input int op, input int sa, input int sb, input int dst, input bit flg);
    clear_wq();
    run_cmd(op, sa, sb, dst, flg, 1'b0);
  endtask

  // Monitor: pops one expectation per bus_valid strobe
  initial begin
    exp_t e;
    mon_active  = 1'b0;
    rd_addr_mon = '0;
    forever begin
      @(negedge clk);
      if (bif.bus_valid) begin
        seen++;
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: bus=%0h with empty queue", bif.bus);
        end else begin
          e = sbq.pop_front();
          chk("bus", int'(bif.bus), int'(e.res));
          chk("done", int'(bif.done), 1);
          chk("wr_conflict", int'(wr_conflict), int'(e.conflict));
          rd_addr_mon = AW'(e.dst);
          mon_active  = 1'b1;
          @(posedge clk);
          #1;
          chk("rd_dst", int'(rd_data), int'(e.res));
          chk("flags", int'(bif.flags), int'(e.flg));
          mon_active = 1'b0;
        end
      end else if (reset) begin
        chk("no_done", int'(bif.done), 0);
        chk("no_conflict", int'(wr_conflict), 0);
      end
    end
  end

  initial begin
    bif.cmd_valid = 1'b0; bif.cmd_op = '0; bif.cmd_src_a = '0;
    bif.cmd_src_b = '0; bif.cmd_dst = '0; bif.cmd_flg_we = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_drv = '0;
    clear_wq();
    for (int i = 0; i < N; i++) mregs[i] = '0;
    mflags = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_cmd_ready", int'(bif.cmd_ready), 1);
    chk("rst_bus", int'(bif.bus), 0);
    chk("rst_bus_valid", int'(bif.bus_valid), 0);
    chk("rst_flags", int'(bif.flags), 0);
    for (int i = 0; i < N; i++) peek("rst_reg", i, '0);

    // Reset mid-EXEC aborts the ADD with no writeback
    tick();
    ext_write(0, 8'h03);
    ext_write(1, 8'h04);
    bif.cmd_valid = 1'b1; bif.cmd_op = 3'd0; bif.cmd_src_a = 2'd0;
    bif.cmd_src_b = 2'd1; bif.cmd_dst = 2'd2; bif.cmd_flg_we = 1'b1;
    tick();
    bif.cmd_valid = 1'b0;
    tick();
    #2 reset = 1'b0;
    for (int i = 0; i < N; i++) mregs[i] = '0;
    mflags = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    chk("abort_cmd_ready", int'(bif.cmd_ready), 1);
    chk("abort_flags", int'(bif.flags), 0);
    chk("abort_bus", int'(bif.bus), 0);
    peek("abort_r2", 2, '0);
    tick();

    // ADD overflow into sign bit
    ext_write(0, 8'h7F); ext_write(1, 8'h01);
    op_d(0, 0, 1, 2, 1);
    chk("add_bus", int'(bif.bus), 'h80);
    chk("add_flags", int'(bif.flags), 4'b0011);

    // SUB equal and borrow cases
    ext_write(0, 8'h05); ext_write(1, 8'h05);
    op_d(1, 0, 1, 3, 1);
    chk("sub0_flags", int'(bif.flags), 4'b1100);
    peek("sub0_r3", 3, 8'h00);
    ext_write(0, 8'h03);
    op_d(1, 0, 1, 3, 1);
    chk("subneg_bus", int'(bif.bus), 'hFE);
    chk("subneg_flags", int'(bif.flags), 4'b0010);

    // Shifts and logic ops
    ext_write(0, 8'h81);
    op_d(6, 0, 0, 1, 1);
    chk("shl_bus", int'(bif.bus), 'h02);
    chk("shl_flags", int'(bif.flags), 4'b1000);
    op_d(7, 0, 0, 2, 1);
    chk("shr_bus", int'(bif.bus), 'h40);
    chk("shr_flags", int'(bif.flags), 4'b1000);
    ext_write(0, 8'hF0); ext_write(1, 8'h3C);
    op_d(2, 0, 1, 2, 1);
    chk("and_bus", int'(bif.bus), 'h30);
    chk("and_flags", int'(bif.flags), 4'b0000);
    op_d(3, 0, 1, 2, 1);
    chk("or_bus", int'(bif.bus), 'hFC);
    op_d(4, 0, 1, 2, 1);
    chk("xor_bus", int'(bif.bus), 'hCC);
    chk("xor_flags", int'(bif.flags), 4'b0010);

    // External write into dst during WB loses to writeback
    ext_write(0, 8'h10); ext_write(1, 8'h20);
    clear_wq();
    wq_en[3] = 1; wq_addr[3] = 2; wq_data[3] = 8'hAA;
    run_cmd(0, 0, 1, 2, 1'b0, 1'b0);
    peek("conflict_r2", 2, 8'h30);

    // External write to a source during FETCH: old operand used, new value kept
    ext_write(0, 8'h11); ext_write(1, 8'h22);
    clear_wq();
    wq_en[1] = 1; wq_addr[1] = 0; wq_data[1] = 8'h99;
    run_cmd(0, 0, 1, 3, 1'b0, 1'b0);
    peek("fetch_r3", 3, 8'h33);
    peek("fetch_r0", 0, 8'h99);
    chk("flags_hold", int'(bif.flags), 4'b0010);
    tick();

    // Random commands: first back-to-back with cmd_valid held, then with gaps
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 4; k++) begin
        wq_en[k]   = ($urandom_range(0, 2) == 0);
        wq_addr[k] = $urandom_range(0, N - 1);
        wq_data[k] = W'($urandom);
      end
      run_cmd($urandom_range(0, 7), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
              $urandom_range(0, N - 1), 1'($urandom), (n < 20) ? 1'b1 : 1'($urandom));
      if (n >= 20) begin
        repeat ($urandom_range(0, 2)) begin
          if ($urandom_range(0, 1) == 1) ext_write($urandom_range(0, N - 1), W'($urandom));
          else tick();
        end
      end
    end

    repeat (6) tick();
    chk("all_done", seen, issued);
    chk("queue_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
